mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Wishbone-slave sequencer that owns the MAC accelerator datapath inside the user project. Firmware loads two operand vectors and a length over Wishbone, writes START, and the block streams operand pairs into the external multiply-accumulate unit, waits out its pipeline, latches the accumulator and raises an interrupt. It sits between the management-SoC Wishbone port and the MAC datapath, one level below the user project wrapper.

## Interface
- DW, 8: operand width per element.
- AW, 4: log2 of buffer depth; DEPTH = 2^AW = 16 entries per vector.
- ACCW, 32: accumulator/result width.
- MAC_LAT, 2: cycles from the last mac_en beat until mac_acc is final.

- wb_clk_i  in  1  sole clock; all state on its rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to wb_clk_i.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte selects; a write needs sel[0] for buffers, and all four selects for CTRL/LEN.
- wbs_adr_i  in  32  byte address; only [7:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- mac_clr  out  1  clear accumulator, one cycle.
- mac_en  out  1  accumulate mac_a*mac_b this cycle.
- mac_a, mac_b  out  DW  operand pair.
- mac_acc  in  ACCW  accumulator value from the datapath.
- irq  out  1  level interrupt = DONE & IRQ_EN.

## Operation
- Register map (offset = adr[7:0]):
  - 0x00 CTRL: bit0 START (write 1, self-clearing, reads 0), bit1 IRQ_EN (R/W), bit2 CLR_DONE (write 1 clears DONE, reads 0).
  - 0x04 LEN: [AW:0], R/W. Writes above DEPTH saturate to DEPTH.
  - 0x08 STATUS (RO): bit0 BUSY, bit1 DONE, [15:8] current index.
  - 0x0C RESULT (RO): latched accumulator.
  - 0x40–0x7C: A buffer, entry adr[5:2], data [DW-1:0]. 0x80–0xBC: B buffer, same layout. Buffers are readable.
  - Unmapped reads return 0. Unmapped writes are acked and ignored.
- While BUSY, writes to LEN, A and B are acked and dropped; START is ignored. IRQ_EN and CLR_DONE still take effect.
- FSM states:
  - IDLE --START--> CLR. START also clears DONE.
  - CLR: mac_clr=1, idx=0. Goes to DONE_ST if LEN==0, else to RUN.
  - RUN: mac_en=1, mac_a=A[idx], mac_b=B[idx]. idx increments each cycle. When idx==LEN-1, the beat is issued and the FSM moves to DRAIN.
  - DRAIN: counts MAC_LAT cycles with mac_en=0, then moves to DONE_ST.
  - DONE_ST: RESULT<=mac_acc (LEN==0 latches 0), DONE<=1, then IDLE.
- BUSY=1 in every state except IDLE.
- If START and CLR_DONE are written together, START wins and DONE ends at 0.
- mac_a and mac_b hold 0 whenever mac_en=0.

## Timing
- Wishbone: a request is accepted at the edge where cyc&stb&!ack. The write takes effect at that edge. ack=1 for exactly the following cycle, with wbs_dat_o registered. Back-to-back requests therefore complete every 2 cycles.
- With the START write accepted at edge E0: CLR occupies cycle E0+1, and RUN beats occupy cycles E0+2 … E0+1+LEN.
- RESULT and DONE update at the end of cycle E0+2+LEN+MAC_LAT. irq rises in the same cycle DONE does.
- For LEN==0, DONE sets 2 cycles after E0.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, mac_clr=0, mac_en=0, mac_a=0, mac_b=0, irq=0. CTRL, LEN, RESULT, STATUS and both buffers are all 0. FSM=IDLE.
- Reset asserted mid-RUN forces the outputs above to 0 asynchronously. The sequence is abandoned and no DONE is produced.

## Test plan
- A=1,2,3,4; B=5,6,7,8; LEN=4; a behavioral MAC model with MAC_LAT=2 -> 4 mac_en beats with pairs (1,5)…(4,8), RESULT=70, DONE set 8 cycles after the START edge, irq=0 with IRQ_EN=0.
- Same run with IRQ_EN=1 -> irq rises with DONE. Writing CLR_DONE drops irq the next cycle.
- LEN=0, START -> one mac_clr, zero mac_en beats, RESULT=0, DONE after 2 cycles. Writing LEN=31 reads back 16.
- During a LEN=16 run, write START, A[0]=0xFF and LEN=3 -> all acked, none take effect. RESULT matches the original data, and LEN reads 16.
- Assert wb_rst_n_i at the 3rd RUN beat -> mac_en=0 immediately, STATUS=0, A[0] reads 0 after release, no irq.
- Back-to-back Wishbone reads of all four registers -> each ack is exactly one cycle wide and data matches the values above.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Wishbone classic port between the management SoC and the MAC sequencer.
interface mac_seq_ctrl_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Wishbone-programmed sequencer: streams operand pairs from two local buffers into an
// external MAC unit, waits out its latency, latches the accumulator and flags DONE.
module mac_seq_ctrl #(
   parameter int unsigned DW      = 8,
   parameter int unsigned AW      = 4,
   parameter int unsigned ACCW    = 32,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   mac_seq_ctrl_if.slave   wbs,
   output logic            mac_clr,
   output logic            mac_en,
   output logic [DW-1:0]   mac_a,
   output logic [DW-1:0]   mac_b,
   input  logic [ACCW-1:0] mac_acc,
   output logic            irq
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CntW  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

   state_e          state_q;
   logic            ack_q;
   logic [31:0]     dat_q;
   logic            irq_en_q;
   logic            done_q;
   logic [AW:0]     len_q;
   logic [AW-1:0]   idx_q;
   logic [CntW-1:0] cnt_q;
   logic [ACCW-1:0] result_q;
   logic [DW-1:0]   a_q [DEPTH];
   logic [DW-1:0]   b_q [DEPTH];
   logic            mac_clr_q;
   logic            mac_en_q;
   logic [DW-1:0]   mac_a_q;
   logic [DW-1:0]   mac_b_q;

   logic            req;
   logic            wr;
   logic            busy;
   logic            full_sel;
   logic [5:0]      word;
   logic [AW-1:0]   entry;
   logic            sel_a;
   logic            sel_b;
   logic            wr_ctrl;
   logic            start;
   logic            clr_done;
   logic            last_beat;
   logic [31:0]     rdata;
   logic            unused_adr;

   assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
   assign wr        = req & wbs.wbs_we_i;
   assign busy      = (state_q != StIdle);
   assign full_sel  = (wbs.wbs_sel_i == 4'hF);
   assign word      = wbs.wbs_adr_i[7:2];
   assign entry     = wbs.wbs_adr_i[2 +: AW];
   assign sel_a     = (word[5:4] == 2'b01);
   assign sel_b     = (word[5:4] == 2'b10);
   assign wr_ctrl   = wr & (word == 6'd0) & full_sel;
   assign start     = wr_ctrl & wbs.wbs_dat_i[0] & ~busy;
   assign clr_done  = wr_ctrl & wbs.wbs_dat_i[2];
   assign last_beat = ({1'b0, idx_q} == (len_q - 1'b1));
   assign unused_adr = ^{wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0]};

   always_comb begin
      rdata = '0;
      if (sel_a) begin
         rdata = 32'(a_q[entry]);
      end else if (sel_b) begin
         rdata = 32'(b_q[entry]);
      end else begin
         case (word)
            6'd0:    rdata = {30'd0, irq_en_q, 1'b0};
            6'd1:    rdata = 32'(len_q);
            6'd2:    rdata = {16'd0, 8'(idx_q), 6'd0, done_q, busy};
            6'd3:    rdata = 32'(result_q);
            default: rdata = '0;
         endcase
      end
   end

   // Bus side: ack/data pipeline, config registers and operand buffers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         irq_en_q <= 1'b0;
         len_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         ack_q <= req;
         dat_q <= (req && !wbs.wbs_we_i) ? rdata : '0;
         if (wr_ctrl) irq_en_q <= wbs.wbs_dat_i[1];
         if (wr && !busy) begin
            if ((word == 6'd1) && full_sel) begin
               len_q <= (wbs.wbs_dat_i > 32'(DEPTH)) ? (AW+1)'(DEPTH) : wbs.wbs_dat_i[AW:0];
            end
            if (sel_a && wbs.wbs_sel_i[0]) a_q[entry] <= wbs.wbs_dat_i[DW-1:0];
            if (sel_b && wbs.wbs_sel_i[0]) b_q[entry] <= wbs.wbs_dat_i[DW-1:0];
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
         mac_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;
         mac_a_q   <= '0;
         mac_b_q   <= '0;
      end else begin
         mac_clr_q <= 1'b0;
         if (clr_done) done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q   <= StClr;
                  mac_clr_q <= 1'b1;
                  idx_q     <= '0;
                  done_q    <= 1'b0;
               end
            end
            StClr: begin
               idx_q <= '0;
               if (len_q == '0) begin
                  state_q <= StDone;
               end else begin
                  state_q  <= StRun;
                  mac_en_q <= 1'b1;
                  mac_a_q  <= a_q[0];
                  mac_b_q  <= b_q[0];
               end
            end
            StRun: begin
               if (last_beat) begin
                  state_q  <= StDrain;
                  cnt_q    <= '0;
                  mac_en_q <= 1'b0;
                  mac_a_q  <= '0;
                  mac_b_q  <= '0;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  mac_a_q <= a_q[idx_q + 1'b1];
                  mac_b_q <= b_q[idx_q + 1'b1];
               end
            end
            StDrain: begin
               if (cnt_q == CntW'(MAC_LAT - 1)) state_q <= StDone;
               else                             cnt_q   <= cnt_q + 1'b1;
            end
            StDone: begin
               // An empty run never touched the MAC, so its stale accumulator is not reported.
               result_q <= (len_q == '0) ? '0 : mac_acc;
               done_q   <= 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign mac_clr       = mac_clr_q;
   assign mac_en        = mac_en_q;
   assign mac_a         = mac_a_q;
   assign mac_b         = mac_b_q;
   assign irq           = done_q & irq_en_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: register table, directed runs, random runs
// against a sum-of-products reference, and a mid-run reset.
module tb_mac_seq_ctrl;
   localparam int unsigned DW = 8, AW = 4, ACCW = 32, MAC_LAT = 2, DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_seq_ctrl_if wbif();
   logic            mac_clr, mac_en, irq;
   logic [DW-1:0]   mac_a, mac_b;
   logic [ACCW-1:0] mac_acc;

   mac_seq_ctrl #(.DW(DW), .AW(AW), .ACCW(ACCW), .MAC_LAT(MAC_LAT)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wbs        (wbif),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .mac_acc    (mac_acc),
      .irq        (irq)
   );

   // External MAC stand-in: accumulator plus MAC_LAT-1 output delay stages.
   logic [ACCW-1:0] acc0, acc1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc0 <= '0;
         acc1 <= '0;
      end else begin
         if (mac_clr)     acc0 <= '0;
         else if (mac_en) acc0 <= acc0 + 32'(mac_a) * 32'(mac_b);
         acc1 <= acc0;
      end
   end
   assign mac_acc = acc1;

   int unsigned cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   logic [15:0] beats[$];
   int          clr_cnt = 0, hold_err = 0, ack_dbl = 0;
   logic        ack_prev = 1'b0;
   always @(negedge clk) begin
      if (mac_en) beats.push_back({mac_a, mac_b});
      else if (mac_a != '0 || mac_b != '0) hold_err++;
      if (mac_clr) clr_cnt++;
      if (wbif.wbs_ack_o && ack_prev) ack_dbl++;
      ack_prev = wbif.wbs_ack_o;
   end

   int          n_chk = 0, n_err = 0;
   int unsigned last_acc, e0;
   int          beat_base, clr_base;
   int unsigned ref_a[DEPTH], ref_b[DEPTH], ref_len;

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One Wishbone transfer; called just after a rising edge, returns 1 time unit after ack.
   task automatic wb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
      logic got = 1'b0;
      wbif.wbs_cyc_i = 1'b1;
      wbif.wbs_stb_i = 1'b1;
      wbif.wbs_we_i  = w;
      wbif.wbs_adr_i = 32'(a);
      wbif.wbs_dat_i = d;
      wbif.wbs_sel_i = s;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1;
         got = wbif.wbs_ack_o;
      end
      last_acc = cycle;
      rd = wbif.wbs_dat_o;
      wbif.wbs_cyc_i = 1'b0;
      wbif.wbs_stb_i = 1'b0;
      wbif.wbs_we_i  = 1'b0;
      chk($sformatf("ack_adr_%0h", a), 32'(got), 32'd1);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      wb(1'b1, a, d, 4'hF, rd);
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      logic [31:0] rd;
      wb(1'b0, a, 32'd0, 4'hF, rd);
      chk(name, rd & mask, exp);
   endtask

   function automatic int unsigned exp_done_off(input int unsigned len);
      return (len == 0) ? 2 : 2 + len + MAC_LAT;
   endfunction

   // {DONE, BUSY} seen by a read accepted k edges after the START edge.
   function automatic logic [31:0] exp_status(input int k, input int unsigned len);
      return (k - 1 <= int'(exp_done_off(len)) - 1) ? 32'd1 : 32'd2;
   endfunction

   function automatic logic [31:0] ref_sum();
      logic [31:0] s = 0;
      for (int i = 0; i < int'(ref_len); i++) s += 32'(ref_a[i] * ref_b[i]);
      return s;
   endfunction

   task automatic load(input int unsigned raw_len);
      for (int i = 0; i < int'(DEPTH); i++) begin
         wr(8'(32'h40 + 4 * i), ref_a[i]);
         wr(8'(32'h80 + 4 * i), ref_b[i]);
      end
      wr(8'h04, raw_len);
      ref_len = (raw_len > DEPTH) ? DEPTH : raw_len;
   endtask

   task automatic start_run(input logic ien);
      beat_base = beats.size();
      clr_base  = clr_cnt;
      wr(8'h00, ien ? 32'd3 : 32'd1);
      e0 = last_acc;
   endtask

   task automatic wait_irq(input string tag);
      int off = -1;
      for (int c = 0; c < 60 && off < 0; c++) begin
         @(posedge clk);
         #1;
         if (irq) off = int'(cycle - e0);
      end
      chk({tag, "_irq_offset"}, 32'(off), 32'(exp_done_off(ref_len)));
   endtask

   task automatic check_outcome(input string tag);
      int bad = 0;
      rd_chk({tag, "_result"}, 8'h0C, 32'hFFFF_FFFF, ref_sum());
      chk({tag, "_beats"}, 32'(beats.size() - beat_base), 32'(ref_len));
      for (int i = 0; i < int'(ref_len) && beat_base + i < beats.size(); i++)
         if (beats[beat_base + i] != {8'(ref_a[i]), 8'(ref_b[i])}) bad++;
      chk({tag, "_pairs"}, 32'(bad), 32'd0);
      chk({tag, "_clr"}, 32'(clr_cnt - clr_base), 32'd1);
   endtask

   logic [7:0]  b2b_adr[4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
   logic [31:0] b2b_msk[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFF};
   logic [31:0] b2b_exp[4] = '{32'd2, 32'd4, 32'd2, 32'd70};
   string       b2b_nm[4]  = '{"b2b_ctrl", "b2b_len", "b2b_status", "b2b_result"};

   initial begin
      logic [31:0] rd;
      logic [7:0]  ackbits;
      int          n, seen, irq_seen;

      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0; wbif.wbs_we_i = 1'b0;
      wbif.wbs_sel_i = 4'h0; wbif.wbs_adr_i = '0;   wbif.wbs_dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {mac_clr, mac_en, mac_a, mac_b, irq, wbif.wbs_ack_o}, 32'd0);
      chk("reset_dat_o", wbif.wbs_dat_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      vecs.push_back('{1'b0, 8'h00, 32'h0, 4'hF, 32'h0, "rst_ctrl"});
      vecs.push_back('{1'b0, 8'h04, 32'h0, 4'hF, 32'h0, "rst_len"});
      vecs.push_back('{1'b0, 8'h08, 32'h0, 4'hF, 32'h0, "rst_status"});
      vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'hF, 32'h0, "rst_result"});
      vecs.push_back('{1'b0, 8'h40, 32'h0, 4'hF, 32'h0, "rst_a0"});
      vecs.push_back('{1'b0, 8'hBC, 32'h0, 4'hF, 32'h0, "rst_b15"});
      vecs.push_back('{1'b1, 8'h04, 32'd31, 4'hF, 32'd16, "len_sat31"});
      vecs.push_back('{1'b1, 8'h04, 32'd5, 4'hF, 32'd5, "len_5"});
      vecs.push_back('{1'b1, 8'h04, 32'd7, 4'h1, 32'd5, "len_partial_sel"});
      vecs.push_back('{1'b1, 8'h04, 32'd17, 4'hF, 32'd16, "len_sat17"});
      vecs.push_back('{1'b1, 8'h04, 32'd16, 4'hF, 32'd16, "len_16"});
      vecs.push_back('{1'b1, 8'h00, 32'd2, 4'hF, 32'd2, "ctrl_irq_en"});
      vecs.push_back('{1'b1, 8'h00, 32'd0, 4'h7, 32'd2, "ctrl_partial_sel"});
      vecs.push_back('{1'b1, 8'h00, 32'd4, 4'hF, 32'd0, "ctrl_clr_done"});
      vecs.push_back('{1'b1, 8'h4C, 32'h1AB, 4'h1, 32'hAB, "a3_write"});
      vecs.push_back('{1'b1, 8'h4C, 32'h55, 4'h2, 32'hAB, "a3_no_sel0"});
      vecs.push_back('{1'b1, 8'hBC, 32'h7F, 4'hF, 32'h7F, "b15_write"});
      vecs.push_back('{1'b1, 8'hC0, 32'h123, 4'hF, 32'h0, "unmapped_c0"});
      vecs.push_back('{1'b1, 8'h10, 32'h123, 4'hF, 32'h0, "unmapped_10"});
      vecs.push_back('{1'b1, 8'h08, 32'hFFFF, 4'hF, 32'h0, "status_ro"});
      vecs.push_back('{1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, "result_ro"});
      foreach (vecs[i]) begin
         if (vecs[i].we) wb(1'b1, vecs[i].adr, vecs[i].wdat, vecs[i].sel, rd);
         rd_chk(vecs[i].name, vecs[i].adr, 32'hFFFF_FFFF, vecs[i].exp);
      end

      // LEN=4 with IRQ_EN=0: poll STATUS against the start-relative timeline.
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_a[i] = (i < 4) ? i + 1 : 0;
         ref_b[i] = (i < 4) ? i + 5 : 0;
      end
      load(4);
      start_run(1'b0);
      seen = 0;
      irq_seen = 0;
      for (int p = 0; p < 15 && seen == 0; p++) begin
         wb(1'b0, 8'h08, 32'd0, 4'hF, rd);
         chk("t1_status", rd & 32'h3, exp_status(int'(last_acc - e0), ref_len));
         if (rd[1]) seen = 1;
         if (irq) irq_seen = 1;
      end
      chk("t1_done_seen", 32'(seen), 32'd1);
      chk("t1_irq_low", 32'(irq_seen | int'(irq)), 32'd0);
      check_outcome("t1");

      // Same run with IRQ_EN=1, then back-to-back register reads, then CLR_DONE.
      start_run(1'b1);
      wait_irq("t2");
      check_outcome("t2");
      @(posedge clk);
      #1;
      wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b0;
      wbif.wbs_sel_i = 4'hF; wbif.wbs_adr_i = 32'(b2b_adr[0]);
      n = 0;
      ackbits = '0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         ackbits[c] = wbif.wbs_ack_o;
         if (wbif.wbs_ack_o && n < 4) begin
            chk(b2b_nm[n], wbif.wbs_dat_o & b2b_msk[n], b2b_exp[n]);
            n++;
            if (n < 4) wbif.wbs_adr_i = 32'(b2b_adr[n]);
            else begin
               wbif.wbs_cyc_i = 1'b0;
               wbif.wbs_stb_i = 1'b0;
            end
         end
      end
      chk("b2b_ack_pattern", 32'(ackbits), 32'h55);
      chk("t2_irq_high", 32'(irq), 32'd1);
      wr(8'h00, 32'd6);
      chk("t2_irq_dropped", 32'(irq), 32'd0);

      // Empty run.
      wr(8'h04, 32'd0);
      ref_len = 0;
      start_run(1'b1);
      wait_irq("t3");
      check_outcome("t3");
      wr(8'h04, 32'd31);
      rd_chk("t3_len31_readback", 8'h04, 32'hFFFF_FFFF, 32'd16);

      // Writes during a full-length run are acked but dropped.
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_a[i] = $urandom_range(0, 254);
         ref_b[i] = $urandom_range(0, 255);
      end
      load(16);
      start_run(1'b1);
      wr(8'h00, 32'd3);
      wr(8'h40, 32'hFF);
      wr(8'h04, 32'd3);
      wait_irq("t4");
      check_outcome("t4");
      rd_chk("t4_len_kept", 8'h04, 32'hFFFF_FFFF, 32'd16);
      rd_chk("t4_a0_kept", 8'h40, 32'hFFFF_FFFF, ref_a[0]);

      // Random runs; the first one exercises LEN saturation.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ref_a[i] = $urandom_range(0, 255);
            ref_b[i] = $urandom_range(0, 255);
         end
         load((r == 0) ? $urandom_range(17, 40) : $urandom_range(1, 16));
         rd_chk($sformatf("rnd%0d_len", r), 8'h04, 32'hFFFF_FFFF, ref_len);
         start_run(1'b1);
         wait_irq($sformatf("rnd%0d", r));
         check_outcome($sformatf("rnd%0d", r));
      end

      // Reset on the third RUN beat abandons the sequence.
      for (int i = 0; i < int'(DEPTH); i++) begin
         ref_a[i] = $urandom_range(1, 255);
         ref_b[i] = $urandom_range(1, 255);
      end
      load(8);
      start_run(1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pre_mac_en", 32'(mac_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", {mac_clr, mac_en, mac_a, mac_b, irq, wbif.wbs_ack_o}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd_chk("rst_status", 8'h08, 32'hFFFF_FFFF, 32'd0);
      rd_chk("rst_a0", 8'h40, 32'hFFFF_FFFF, 32'd0);
      irq_seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (irq || mac_en) irq_seen = 1;
      end
      chk("rst_no_resume", 32'(irq_seen), 32'd0);
      rd_chk("rst_status_late", 8'h08, 32'hFFFF_FFFF, 32'd0);

      chk("mac_ab_zero_when_idle", 32'(hold_err), 32'd0);
      chk("ack_single_cycle", 32'(ack_dbl), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
